// File: rtl/mchan_synch_pkg.sv
// rtl/mchan_synch_pkg.sv - shared widths and command entry type for synch release
package mchan_synch_pkg;

  localparam int unsigned TRANS_SID_WIDTH_DEF = 4;
  localparam int unsigned BEAT_CNT_WIDTH_DEF  = 4;
  localparam int unsigned CMD_QUEUE_DEPTH_DEF = 4;

  typedef struct packed {
    logic [TRANS_SID_WIDTH_DEF-1:0] sid;
    logic [BEAT_CNT_WIDTH_DEF-1:0]  len;
  } cmd_entry_t;

endpackage

// File: rtl/synch_cmd_fifo.sv
// rtl/synch_cmd_fifo.sv - in-flight command FIFO with extra-MSB full/empty pointers
module synch_cmd_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Push and pop are self-guarded so callers may present raw requests.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/synch_release_gen.sv
// rtl/synch_release_gen.sv - counts retired beats per command and emits SID release pulses
module synch_release_gen
  import mchan_synch_pkg::*;
#(
  parameter int unsigned TRANS_SID_WIDTH = TRANS_SID_WIDTH_DEF,
  parameter int unsigned BEAT_CNT_WIDTH  = BEAT_CNT_WIDTH_DEF,
  parameter int unsigned CMD_QUEUE_DEPTH = CMD_QUEUE_DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_req_i,
  output logic                       cmd_gnt_o,
  input  logic [TRANS_SID_WIDTH-1:0] cmd_sid_i,
  input  logic [BEAT_CNT_WIDTH-1:0]  cmd_len_i,
  input  logic                       beat_valid_i,
  output logic                       synch_req_o,
  output logic [TRANS_SID_WIDTH-1:0] synch_sid_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned ENTRY_W = TRANS_SID_WIDTH + BEAT_CNT_WIDTH;

  logic                       full, empty, push, pop;
  logic [ENTRY_W-1:0]         head;
  logic [TRANS_SID_WIDTH-1:0] head_sid;
  logic [BEAT_CNT_WIDTH-1:0]  head_len;

  logic [BEAT_CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                       synch_req_q, synch_req_d;
  logic [TRANS_SID_WIDTH-1:0] synch_sid_q, synch_sid_d;
  logic                       err_q, err_d;

  assign {head_sid, head_len} = head;
  assign push = cmd_req_i && !full;

  synch_cmd_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (CMD_QUEUE_DEPTH)
  ) i_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  ({cmd_sid_i, cmd_len_i}),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // A beat seen while empty is dropped, even if a push lands in the same cycle.
  always_comb begin
    pop         = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    synch_req_d = 1'b0;
    synch_sid_d = synch_sid_q;
    err_d       = err_q;
    if (beat_valid_i) begin
      if (empty) begin
        err_d = 1'b1;
      end else if (beat_cnt_q == head_len) begin
        pop         = 1'b1;
        beat_cnt_d  = '0;
        synch_req_d = 1'b1;
        synch_sid_d = head_sid;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q  <= '0;
      synch_req_q <= 1'b0;
      synch_sid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      synch_req_q <= synch_req_d;
      synch_sid_q <= synch_sid_d;
      err_q       <= err_d;
    end
  end

  assign cmd_gnt_o   = !full;
  assign busy_o      = !empty;
  assign synch_req_o = synch_req_q;
  assign synch_sid_o = synch_sid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_synch_release_gen.sv
// tb/tb_synch_release_gen.sv - directed vector table plus reset and random scoreboard sequences
module tb_synch_release_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_req = 1'b0;
  logic       cmd_gnt;
  logic [3:0] cmd_sid = '0;
  logic [3:0] cmd_len = '0;
  logic       beat = 1'b0;
  logic       synch_req;
  logic [3:0] synch_sid;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  synch_release_gen dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_req_i    (cmd_req),
    .cmd_gnt_o    (cmd_gnt),
    .cmd_sid_i    (cmd_sid),
    .cmd_len_i    (cmd_len),
    .beat_valid_i (beat),
    .synch_req_o  (synch_req),
    .synch_sid_o  (synch_sid),
    .busy_o       (busy),
    .err_o        (err)
  );

  typedef struct {
    logic       req;
    logic [3:0] sid;
    logic [3:0] len;
    logic       beat;
    logic       gnt;
    logic       sr;
    logic [3:0] ssid;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic req, input int sid, input int len, input logic b,
                              input logic gnt, input logic sr, input int ssid,
                              input logic bsy, input logic e);
    vec_t v;
    v.req = req; v.sid = sid[3:0]; v.len = len[3:0]; v.beat = b;
    v.gnt = gnt; v.sr = sr; v.ssid = ssid[3:0]; v.busy = bsy; v.err = e;
    return v;
  endfunction

  // scoreboard state for the random phase
  int sid_m[$];
  int len_m[$];
  int cnt_m = 0;
  int pulses_dut = 0;
  int pulses_exp = 0;

  task automatic rand_cycle(input bit allow_req);
    bit req_r, beat_r, acc, exp_pulse;
    int exp_sid;
    req_r  = allow_req && ($urandom_range(0, 1) == 1);
    beat_r = (sid_m.size() > 0) && ($urandom_range(0, 2) != 0);
    cmd_req = req_r;
    cmd_sid = 4'($urandom_range(0, 15));
    cmd_len = 4'($urandom_range(0, 3));
    beat    = beat_r;
    #1;
    chk("rnd_gnt", cmd_gnt, (sid_m.size() < 4));
    acc = req_r && (sid_m.size() < 4);
    exp_pulse = 1'b0;
    exp_sid   = 0;
    if (beat_r) begin
      if (cnt_m == len_m[0]) begin
        exp_pulse = 1'b1;
        exp_sid   = sid_m.pop_front();
        void'(len_m.pop_front());
        cnt_m = 0;
      end else begin
        cnt_m++;
      end
    end
    if (acc) begin
      sid_m.push_back(int'(cmd_sid));
      len_m.push_back(int'(cmd_len));
    end
    @(posedge clk); #1;
    chk("rnd_req", synch_req, exp_pulse);
    if (exp_pulse) begin
      chk("rnd_sid", synch_sid, exp_sid);
      pulses_exp++;
    end
    if (synch_req) pulses_dut++;
    chk("rnd_busy", busy, (sid_m.size() > 0));
  endtask

  initial begin
    // single command, back-to-back zero-length with full queue, orphan beats
    tbl[0]  = mk(1, 3, 3, 0,  1, 0, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 1,  1, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 1,  1, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 1,  1, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1,  1, 1, 3, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,  1, 0, 3, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0,  1, 0, 3, 1, 0);
    tbl[7]  = mk(1, 2, 0, 0,  1, 0, 3, 1, 0);
    tbl[8]  = mk(1, 3, 0, 0,  1, 0, 3, 1, 0);
    tbl[9]  = mk(1, 4, 0, 0,  0, 0, 3, 1, 0);
    tbl[10] = mk(1, 5, 0, 1,  1, 1, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 1,  1, 1, 2, 1, 0);
    tbl[12] = mk(0, 0, 0, 1,  1, 1, 3, 1, 0);
    tbl[13] = mk(0, 0, 0, 1,  1, 1, 4, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,  1, 0, 4, 0, 0);
    tbl[15] = mk(0, 0, 0, 1,  1, 0, 4, 0, 1);
    tbl[16] = mk(1, 7, 1, 1,  1, 0, 4, 1, 1);
    tbl[17] = mk(0, 0, 0, 1,  1, 0, 4, 1, 1);
    tbl[18] = mk(0, 0, 0, 1,  1, 1, 7, 0, 1);
    tbl[19] = mk(0, 0, 0, 0,  1, 0, 7, 0, 1);

    #12;
    chk("rst_gnt", cmd_gnt, 1);
    chk("rst_req", synch_req, 0);
    chk("rst_sid", synch_sid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cmd_req = tbl[i].req;
      cmd_sid = tbl[i].sid;
      cmd_len = tbl[i].len;
      beat    = tbl[i].beat;
      @(posedge clk); #1;
      chk($sformatf("v%0d_gnt", i), cmd_gnt, tbl[i].gnt);
      chk($sformatf("v%0d_req", i), synch_req, tbl[i].sr);
      chk($sformatf("v%0d_sid", i), synch_sid, tbl[i].ssid);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_err", i), err, tbl[i].err);
    end

    // reset mid-transfer: sid 10 completes, sid 9 (len 7) aborted after 3 beats
    cmd_req = 1; cmd_sid = 4'd10; cmd_len = 4'd0; beat = 0;
    @(posedge clk); #1;
    cmd_req = 1; cmd_sid = 4'd9; cmd_len = 4'd7; beat = 1;
    @(posedge clk); #1;
    chk("mid_pulse10", synch_req, 1);
    chk("mid_sid10", synch_sid, 10);
    cmd_req = 0; beat = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_busy", busy, 1);
    beat = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", cmd_gnt, 1);
    chk("arst_req", synch_req, 0);
    chk("arst_sid", synch_sid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    pulses_dut = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (synch_req) pulses_dut++;
    end
    chk("abort_pulses", pulses_dut, 0);
    chk("abort_busy", busy, 0);

    // random interleave against a queue scoreboard, then drain
    pulses_dut = 0;
    for (int c = 0; c < 300; c++) rand_cycle(1'b1);
    for (int c = 0; c < 200 && sid_m.size() > 0; c++) rand_cycle(1'b0);
    chk("drain_empty", sid_m.size(), 0);
    chk("pulse_total", pulses_dut, pulses_exp);
    chk("rnd_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/synch_release_gen.md
# synch_release_gen

Release-side counterpart of the per-transfer synchronization counters. It is placed at the TCDM or EXT end of a channel. It records every burst command issued toward the memory side together with its transaction SID and beat count, and counts retired response beats in order. On the last beat of each command it emits a one-cycle synch pulse carrying that command's SID, which drives the `*_synch_req_i` / `*_synch_sid_i` release inputs of the synchronization units.

## Interface
Parameters:
- `TRANS_SID_WIDTH`, default 4: width of the transaction SID.
- `BEAT_CNT_WIDTH`, default 4: width of the command length field, encoded as beats−1 (up to 16 beats per command).
- `CMD_QUEUE_DEPTH`, default 4: in-flight command entries. Must be a power of two and ≥2.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. Asynchronous, active-low; one clock.
- `cmd_req_i`, in, 1: command issue request.
- `cmd_gnt_o`, out, 1: command accepted when `cmd_req_i && cmd_gnt_o`.
- `cmd_sid_i`, in, `TRANS_SID_WIDTH`: SID of the issued command.
- `cmd_len_i`, in, `BEAT_CNT_WIDTH`: beats−1 of the issued command.
- `beat_valid_i`, in, 1: one response beat retired, strictly in command order.
- `synch_req_o`, out, 1: release pulse, one cycle per completed command.
- `synch_sid_o`, out, `TRANS_SID_WIDTH`: SID qualifying `synch_req_o`.
- `busy_o`, out, 1: at least one command is in flight.
- `err_o`, out, 1: sticky. Set when a beat arrives with no command in flight.

## Operation
- **Command queue.** FIFO of `{sid, len}` entries with `CMD_QUEUE_DEPTH` entries.
  - Push on `cmd_req_i && cmd_gnt_o`.
  - `cmd_gnt_o = !full`, combinational from registered pointers only. There is no same-cycle bypass, so a full queue stalls issue even when a pop happens in that cycle.
- **Beat counter.** Width `BEAT_CNT_WIDTH`. It counts retired beats of the head entry.
  - On `beat_valid_i` with the queue non-empty: if `beat_cnt == head.len` (last beat), pop the head, reset `beat_cnt` to 0 and schedule a synch for `head.sid`. Otherwise increment `beat_cnt`.
  - A `len=0` command completes on its single beat.
- **Beat with queue empty.** This includes a beat in the same cycle as the first push into an empty queue.
  - The beat is dropped and `err_o` is set.
  - `err_o` clears only on reset.
- **Output pulse.** The pulse is registered: `synch_req_o` and `synch_sid_o` are loaded in the cycle of the last beat and are valid the following cycle.
  - `synch_sid_o` holds its last value when `synch_req_o` is 0.
- **Status.** `busy_o = !empty`, registered-pointer based.
- **Simultaneous push and pop.**
  - Both take effect and the occupancy is unchanged.
  - Pointers wrap modulo `CMD_QUEUE_DEPTH`. Full and empty are distinguished by an extra pointer MSB.
- **Reset mid-operation.** All in-flight entries are discarded and no synch pulse is emitted for them. The downstream synchronization units are reset by the same `rst_ni`.

## Timing
- Reset values:
  - `cmd_gnt_o=1`
  - `synch_req_o=0`
  - `synch_sid_o=0`
  - `busy_o=0`
  - `err_o=0`
  - queue empty, `beat_cnt=0`
- Latency from the last beat to `synch_req_o` is exactly 1 cycle.
- Back-to-back `len=0` commands with a beat every cycle produce `synch_req_o` high on consecutive cycles, each with the matching SID. Pulses must not be merged.
- Command issue to its first beat can be 1 cycle minimum: the beat may arrive in the cycle after the push.
- `busy_o` falls in the cycle after the pop of the last entry. It rises in the cycle after the first push.
- Steady state sustains one command issue per cycle and one beat per cycle.

## Structure
- Shared package `mchan_synch_pkg`:
  - typedef `cmd_entry_t` (`sid`, `len`), parameterized through the package constants.
  - constants for the default SID, length and depth widths.
- The FIFO storage, pointers and full/empty logic go in one sub-module, `synch_cmd_fifo`, with push/pop/full/empty and a head output.
- The top level contains the beat counter, the error flag and the output register.

## Test plan
- **Single command.** Issue `sid=3`, `len=3`, then 4 beats on consecutive cycles → `synch_req_o=1` with `synch_sid_o=3` exactly one cycle after the 4th beat. `busy_o` returns to 0 the same cycle.
- **Back-to-back zero-length.** Issue 4 commands, `sid=1,2,3,4`, all `len=0`, then 4 consecutive beats → 4 consecutive pulses with SIDs 1,2,3,4. `cmd_gnt_o` is 0 after the 4th push until the first pop.
- **Full queue.** Hold `cmd_req_i=1` with the queue full and a beat popping in the same cycle → `cmd_gnt_o` stays 0 that cycle and returns to 1 the next. No entry is lost or duplicated.
- **Orphan beat.** `beat_valid_i` with the queue empty → no pulse, `err_o=1` persists. A subsequent normal command still completes correctly.
- **Reset mid-transfer.** Issue `len=7`, retire 3 beats, assert `rst_ni=0` → all outputs take their reset values asynchronously. After release, no pulse appears for the aborted command.
- **Random interleave.** Random issue and beat streams at depth 4 → each `synch_req_o` SID matches the issue order. The total pulse count equals the number of completed commands.
